// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle PC/fetch sequencer with one instruction in flight.
// Fetches into instr, waits one EXEC cycle for decode, optionally runs a data
// access, then commits and steps the PC. HALTED is absorbing until reset.
module fetch_sequencer #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        dhit,
   input  logic        halt_in,
   input  logic        memREN,
   input  logic        memWEN,
   input  logic [1:0]  pc_sel,
   input  logic        brEn,
   input  logic [31:0] rs_data,
   output logic [31:0] instr,
   output logic [31:0] imemaddr,
   output logic        imemREN,
   output logic        dmemREN,
   output logic        dmemWEN,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        commit,
   output logic        halt
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_EXEC   = 2'd1,
      S_DATA   = 2'd2,
      S_HALTED = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   instr_q, instr_d;
   logic              halt_q, halt_d;
   logic [XLEN-1:0]   pc_plus4_c;
   logic [XLEN-1:0]   br_off_c;
   logic [XLEN-1:0]   next_pc_c;

   // State and architectural registers; reset aborts any access in progress.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= S_FETCH;
         pc_q    <= PC_INIT;
         instr_q <= '0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         halt_q  <= halt_d;
      end
   end

   // Next-PC selection from the decode of the latched instruction.
   always_comb begin
      pc_plus4_c = pc_q + XLEN'(4);
      br_off_c   = {{(XLEN-18){instr_q[15]}}, instr_q[15:0], 2'b00};
      next_pc_c  = pc_plus4_c;
      case (pc_sel)
         2'b00:   next_pc_c = brEn ? (pc_plus4_c + br_off_c) : pc_plus4_c;
         2'b01:   next_pc_c = rs_data;
         2'b10:   next_pc_c = {pc_plus4_c[31:28], instr_q[25:0], 2'b00};
         default: next_pc_c = pc_plus4_c;
      endcase
   end

   // Sequencer next-state and request/commit outputs.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      halt_d  = halt_q;
      imemREN = 1'b0;
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
      commit  = 1'b0;
      case (state_q)
         S_FETCH: begin
            imemREN = 1'b1;
            if (ihit) begin
               instr_d = imemload;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (halt_in) begin
               halt_d  = 1'b1;
               state_d = S_HALTED;
            end else if (memREN || memWEN) begin
               state_d = S_DATA;
            end else begin
               commit  = 1'b1;
               pc_d    = next_pc_c;
               state_d = S_FETCH;
            end
         end
         S_DATA: begin
            // A simultaneous read and write decode is treated as a write.
            dmemWEN = memWEN;
            dmemREN = memREN && !memWEN;
            if (dhit) begin
               commit  = 1'b1;
               pc_d    = next_pc_c;
               state_d = S_FETCH;
            end
         end
         S_HALTED: begin
            halt_d = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign instr    = instr_q;
   assign pc       = pc_q;
   assign imemaddr = pc_q;
   assign pc_plus4 = pc_plus4_c;
   assign halt     = halt_q;

endmodule
